// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port (ALU vs load unit),
// with a destination-register busy scoreboard and issue-stage hazard detection.
module regfile_wb_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RES_VALID,
  input  logic [ADDR_W-1:0]    RES_ADDR,
  input  logic [ADDR_W-1:0]    RD_ADDR1,
  input  logic [ADDR_W-1:0]    RD_ADDR2,
  input  logic                 A_VALID,
  input  logic [ADDR_W-1:0]    A_ADDR,
  input  logic [DATA_W-1:0]    A_DATA,
  output logic                 A_READY,
  input  logic                 B_VALID,
  input  logic [ADDR_W-1:0]    B_ADDR,
  input  logic [DATA_W-1:0]    B_DATA,
  output logic                 B_READY,
  output logic                 W_EN,
  output logic [ADDR_W-1:0]    address,
  output logic [DATA_W-1:0]    INIT,
  output logic [2**ADDR_W-1:0] BUSY,
  output logic                 HAZARD
);

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  prio_t               prio;
  logic [2**ADDR_W-1:0] busy;
  logic [2**ADDR_W-1:0] busy_nxt;
  logic                grant_a;
  logic                grant_b;
  logic                accept;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;

  // Grants are suppressed during reset so no handshake can complete then.
  assign grant_a  = !RST && A_VALID && (!B_VALID || (prio == PRIO_A));
  assign grant_b  = !RST && B_VALID && (!A_VALID || (prio == PRIO_B));
  assign accept   = grant_a || grant_b;
  assign acc_addr = grant_a ? A_ADDR : B_ADDR;
  assign acc_data = grant_a ? A_DATA : B_DATA;

  assign A_READY = grant_a;
  assign B_READY = grant_b;
  assign BUSY    = busy;

  // A reservation in the same cycle as the write it replaces means a newer write is pending.
  always_comb begin
    busy_nxt = busy;
    if (accept) busy_nxt[acc_addr] = 1'b0;
    if (RES_VALID) busy_nxt[RES_ADDR] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  assign HAZARD = busy[RD_ADDR1] | busy[RD_ADDR2] | (RES_VALID & busy[RES_ADDR]);

  always_ff @(posedge CLK) begin
    if (RST) begin
      prio    <= PRIO_A;
      busy    <= '0;
      W_EN    <= 1'b0;
      address <= '0;
      INIT    <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        W_EN    <= (acc_addr != '0);
        address <= acc_addr;
        INIT    <= acc_data;
        prio    <= grant_a ? PRIO_B : PRIO_A;
      end else begin
        W_EN <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, scoreboard/hazard, round-robin,
// x0 handling, set-over-clear and reset cancelling an in-flight write.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              res_valid;
  logic [ADDR_W-1:0] res_addr;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              w_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] init;
  logic [15:0]       busy;
  logic              hazard;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst),
    .RES_VALID(res_valid), .RES_ADDR(res_addr),
    .RD_ADDR1(rd_addr1), .RD_ADDR2(rd_addr2),
    .A_VALID(a_valid), .A_ADDR(a_addr), .A_DATA(a_data), .A_READY(a_ready),
    .B_VALID(b_valid), .B_ADDR(b_addr), .B_DATA(b_data), .B_READY(b_ready),
    .W_EN(w_en), .address(address), .INIT(init),
    .BUSY(busy), .HAZARD(hazard)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [ADDR_W-1:0] exp_addr [4];
  logic [DATA_W-1:0] exp_data [4];

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    a_valid = 1'b1; a_addr = 4'd3; a_data = 16'h0304;
    b_valid = 1'b1; b_addr = 4'd4; b_data = 16'h00FF;

    // 1: reset held with both requesters valid
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("rst_a_ready", a_ready, 0);
      check_val("rst_b_ready", b_ready, 0);
      check_val("rst_w_en", w_en, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_hazard", hazard, 0);
    end

    // 2: reserve r5, hazard on read, ALU writeback clears it
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    res_valid = 1'b1; res_addr = 4'd5;
    tick();
    res_valid = 1'b0;
    check_val("res5_busy", busy, 32'h0020);
    rd_addr1 = 4'd5;
    #1 check_val("raw_hazard1", hazard, 1);
    rd_addr1 = 4'd0; rd_addr2 = 4'd5;
    #1 check_val("raw_hazard2", hazard, 1);
    rd_addr2 = 4'd0; rd_addr1 = 4'd5;
    a_valid = 1'b1; a_addr = 4'd5; a_data = 16'h0009;
    #1 check_val("a5_ready", a_ready, 1);
    check_val("a5_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0;
    check_val("a5_w_en", w_en, 1);
    check_val("a5_address", address, 5);
    check_val("a5_init", init, 16'h0009);
    check_val("a5_busy", busy, 0);
    #1 check_val("a5_hazard", hazard, 0);
    rd_addr1 = 4'd0;

    // 3: round-robin from reset with both valid
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 4'd3; a_data = 16'h0304;
    b_valid = 1'b1; b_addr = 4'd4; b_data = 16'h00FF;
    exp_addr[0] = 4'd3; exp_data[0] = 16'h0304;
    exp_addr[1] = 4'd4; exp_data[1] = 16'h00FF;
    exp_addr[2] = 4'd3; exp_data[2] = 16'h0304;
    exp_addr[3] = 4'd4; exp_data[3] = 16'h00FF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_val($sformatf("rr%0d_a_ready", i), a_ready, (i % 2 == 0) ? 1 : 0);
      check_val($sformatf("rr%0d_b_ready", i), b_ready, (i % 2 == 0) ? 0 : 1);
      tick();
      check_val($sformatf("rr%0d_w_en", i), w_en, 1);
      check_val($sformatf("rr%0d_address", i), address, exp_addr[i]);
      check_val($sformatf("rr%0d_init", i), init, exp_data[i]);
    end
    a_valid = 1'b0; b_valid = 1'b0;

    // 4: x0 write handshakes without W_EN; reserving x0 leaves BUSY alone
    res_valid = 1'b1; res_addr = 4'd2;
    tick();
    check_val("res2_busy", busy, 32'h0004);
    res_addr = 4'd0;
    b_valid = 1'b1; b_addr = 4'd0; b_data = 16'hBEEF;
    #1 check_val("x0_b_ready", b_ready, 1);
    tick();
    b_valid = 1'b0; res_valid = 1'b0;
    check_val("x0_w_en", w_en, 0);
    check_val("x0_busy", busy, 32'h0004);

    // 5: re-reserve r7 while its pending write is accepted
    res_valid = 1'b1; res_addr = 4'd7;
    tick();
    check_val("res7_busy", busy, 32'h0084);
    a_valid = 1'b1; a_addr = 4'd7; a_data = 16'h0707;
    #1 check_val("waw_hazard", hazard, 1);
    check_val("waw_a_ready", a_ready, 1);
    tick();
    a_valid = 1'b0; res_valid = 1'b0;
    check_val("waw_busy", busy, 32'h0084);
    check_val("waw_w_en", w_en, 1);
    check_val("waw_address", address, 7);

    // idle cycle: W_EN drops, address/INIT hold
    tick();
    check_val("idle_w_en", w_en, 0);
    check_val("idle_address", address, 7);
    check_val("idle_init", init, 16'h0707);

    // 6: reset in the same cycle as an ALU request
    a_valid = 1'b1; a_addr = 4'd6; a_data = 16'h0606;
    rst = 1'b1;
    #1 check_val("rstmid_a_ready", a_ready, 0);
    tick();
    check_val("rstmid_w_en", w_en, 0);
    check_val("rstmid_busy", busy, 0);
    rst = 1'b0; a_valid = 1'b0;
    tick();
    check_val("post_rst_w_en", w_en, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
